residue_convergence_monitor: RTL and testbench
==============================================

Name: residue_convergence_monitor

Overview:
Downstream consumer of the PE array's bit-serial residue outputs. It collects one WIDTH-bit two's-complement residue word per PE lane, with all lanes sampled in parallel, LSB first. It evaluates |residue| against a programmable threshold and counts Jacobi iterations. It declares convergence after STABLE_CNT consecutive all-lanes-within-threshold iterations, or timeout at max_iter. The sequencer uses done/converged to stop the iteration and start the solution read-out.

Parameters:
WIDTH, 8, residue word width in bits (serial length per iteration)
NUM_PE, 4, number of PE residue lanes sampled in parallel
ITER_W, 16, width of iteration counter and max_iter
STABLE_CNT, 2, consecutive passing iterations required to declare convergence (>=1)

Ports:
clk_a  input  1  clock; same domain that shifts the PE serializer
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a monitoring run (honoured in IDLE and DONE only)
abort  input  1  synchronous abort; returns to IDLE from any state
bit_valid  input  1  residue_in carries a valid bit this cycle
residue_in  input  NUM_PE  serial residue bit per lane, LSB first
threshold  input  WIDTH  unsigned magnitude limit; sampled at start
max_iter  input  ITER_W  iteration limit, 0 = unlimited; sampled at start
busy  output  1  high in SHIFT and EVAL
word_valid  output  1  one-cycle pulse when a full word set is evaluated
lane_ok  output  NUM_PE  per-lane |res|<=threshold result of last evaluation
max_abs  output  WIDTH  largest |res| across lanes in last evaluation
iter_count  output  ITER_W  iterations evaluated in current run
done  output  1  run finished; held until start or abort
converged  output  1  valid when done: 1 = converged, 0 = timeout
timeout  output  1  valid when done: max_iter reached without convergence

Behaviour:
- Reset: state=IDLE; all outputs 0; shift registers, bit counter, stable counter, latched threshold/max_iter all 0.
- States: IDLE, SHIFT, EVAL, DONE. State and all outputs are registered.
- IDLE: start=1 -> SHIFT. Latch threshold and max_iter. Clear bit_cnt, stable_cnt, iter_count, lane_ok, max_abs, done, converged, timeout.
- SHIFT: each cycle with bit_valid=1, shift every lane register right and load the new bit into the MSB. Increment bit_cnt. When the WIDTH-th valid bit is sampled, the next state is EVAL and bit_cnt returns to 0. bit_valid=0 holds all state.
- EVAL (exactly one cycle, word_valid=1):
  - abs = (MSB ? -res : res). -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
  - lane_ok[i] = abs_i <= threshold. max_abs = max of abs_i.
  - iter_count increments and saturates at all-ones.
  - All lanes ok -> stable_cnt+1. Otherwise stable_cnt=0.
  - Priority: new stable_cnt==STABLE_CNT -> DONE with converged=1. Else max_iter!=0 and new iter_count==max_iter -> DONE with timeout=1. Else -> SHIFT.
  - Convergence wins over timeout when both occur in the same EVAL.
- bit_valid and residue_in are ignored in EVAL. The PE serializer guarantees at least one idle cycle between words; a bit presented during EVAL is dropped, not buffered.
- DONE: done=1, outputs frozen. start=1 -> same action as in IDLE (restart). abort -> IDLE.
- abort=1 in any state: next cycle IDLE with all outputs and counters cleared. abort beats start if both are high.
- start during SHIFT or EVAL is ignored.
- rst_n asserted mid-run: immediate return to reset values; a partial word is discarded.
- Latency: word_valid fires 1 cycle after the sampling edge of the last valid bit. done rises 1 cycle after the deciding word_valid.

Test Plan:
- Single lane value: NUM_PE=4, threshold=5, STABLE_CNT=2. Stream per-iteration words {3,-4,0,5} twice -> word_valid twice, lane_ok=4'hF, max_abs=5, done=1 and converged=1 with iter_count=2.
- Sign/saturation: lanes {-128,127,-1,0}, threshold=127 -> max_abs=127, lane_ok=4'hF. Repeat with threshold=126 -> lane_ok=4'b1100 (lanes 0,1 fail), stable_cnt resets.
- Timeout: max_iter=3, lane0 always 20, threshold=10 -> done after 3rd word_valid, timeout=1, converged=0, iter_count=3. max_iter=0 -> still busy after 50 words.
- Gapped bits: bit_valid toggling 1-0-1 across 16 cycles for one 8-bit word -> exactly one word_valid, correct value (e.g. 0x5A -> abs 90).
- Abort/restart: abort after 4 of 8 bits -> IDLE, busy=0. Then start with a fresh word -> counts from bit 0. start during SHIFT has no effect.
- Async reset asserted while in DONE -> all outputs 0 immediately. start after release begins a new run correctly.

Source files
------------

// File: rtl/residue_convergence_monitor.sv
// -----------------------------------------------------------------------------
// residue_convergence_monitor
//
// Purpose:
//   Assembles one WIDTH-bit two's-complement residue word per PE lane from the
//   PE array's bit-serial outputs (all lanes in parallel, LSB first).
//   Each assembled word set is evaluated as |residue| <= threshold. A run
//   ends in one of two ways:
//     - converged, after STABLE_CNT consecutive iterations in which every
//       lane passes;
//     - timeout, when the iteration count reaches max_iter (0 = unlimited).
//
// Ports:
//   clk_a       clock (same domain as the PE serializer)
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a run (honoured in IDLE/DONE only)
//   abort       synchronous return to IDLE, clears outputs and counters
//   bit_valid   residue_in carries a valid bit this cycle
//   residue_in  one serial residue bit per lane
//   threshold   unsigned magnitude limit, latched at start
//   max_iter    iteration limit (0 = unlimited), latched at start
//   busy        high while in SHIFT or EVAL
//   word_valid  one-cycle pulse while a word set is evaluated
//   lane_ok     per-lane pass flags of the last evaluation
//   max_abs     largest |residue| across lanes in the last evaluation
//   iter_count  iterations evaluated in the current run (saturating)
//   done        run finished; held until start or abort
//   converged   valid with done: run converged
//   timeout     valid with done: max_iter reached without convergence
// -----------------------------------------------------------------------------
module residue_convergence_monitor #(
  parameter int WIDTH      = 8,
  parameter int NUM_PE     = 4,
  parameter int ITER_W     = 16,
  parameter int STABLE_CNT = 2
) (
  input  logic              clk_a,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_valid,
  input  logic [NUM_PE-1:0] residue_in,
  input  logic [WIDTH-1:0]  threshold,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              word_valid,
  output logic [NUM_PE-1:0] lane_ok,
  output logic [WIDTH-1:0]  max_abs,
  output logic [ITER_W-1:0] iter_count,
  output logic              done,
  output logic              converged,
  output logic              timeout
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SC_W = $clog2(STABLE_CNT + 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [SC_W-1:0]   r_stable_cnt;
  logic [WIDTH-1:0]  r_threshold;
  logic [ITER_W-1:0] r_max_iter;
  logic              r_busy;
  logic              r_word_valid;
  logic [NUM_PE-1:0] r_lane_ok;
  logic [WIDTH-1:0]  r_max_abs;
  logic [ITER_W-1:0] r_iter_count;
  logic              r_done;
  logic              r_converged;
  logic              r_timeout;

  // Only WIDTH-1 bits per lane are stored: the final bit of a word is taken
  // straight from residue_in on the cycle it arrives, so the complete word is
  // available for evaluation on the same edge that samples its last bit.
  logic [WIDTH-2:0]  r_shift [NUM_PE];

  logic [WIDTH-1:0]  w_word [NUM_PE];
  logic [WIDTH-1:0]  w_abs  [NUM_PE];
  logic [NUM_PE-1:0] w_ok;
  logic [WIDTH-1:0]  w_max;
  logic              w_all_ok;
  logic [SC_W-1:0]   w_stable_next;
  logic [ITER_W-1:0] w_iter_next;
  logic              w_last_bit;

  // Per-lane word assembly and magnitude with saturation of the most
  // negative value (its negation does not fit in WIDTH bits).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic [WIDTH-1:0] w_neg;
      assign w_word[gi] = {residue_in[gi], r_shift[gi]};
      assign w_neg      = ~w_word[gi] + 1'b1;
      assign w_abs[gi]  = !w_word[gi][WIDTH-1]     ? w_word[gi] :
                          (w_word[gi] == MOST_NEG) ? MOST_POS   : w_neg;
      assign w_ok[gi]   = (w_abs[gi] <= r_threshold);
    end
  endgenerate

  always_comb begin
    w_max = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (w_abs[i] > w_max) begin
        w_max = w_abs[i];
      end
    end
  end

  assign w_all_ok      = &w_ok;
  assign w_stable_next = w_all_ok ? (r_stable_cnt + SC_W'(1)) : '0;
  assign w_iter_next   = (&r_iter_count) ? r_iter_count : (r_iter_count + ITER_W'(1));
  assign w_last_bit    = bit_valid && (r_bit_cnt == BC_W'(WIDTH - 1));

  // Evaluation results (lane_ok, max_abs, iter_count, stable count) are
  // registered on the edge that samples the last bit, so they are presented
  // together with word_valid during the EVAL cycle. EVAL then only decides
  // where to go next from those registered values.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_stable_cnt <= '0;
      r_threshold  <= '0;
      r_max_iter   <= '0;
      r_busy       <= 1'b0;
      r_word_valid <= 1'b0;
      r_lane_ok    <= '0;
      r_max_abs    <= '0;
      r_iter_count <= '0;
      r_done       <= 1'b0;
      r_converged  <= 1'b0;
      r_timeout    <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        r_shift[i] <= '0;
      end
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_stable_cnt <= '0;
      r_threshold  <= '0;
      r_max_iter   <= '0;
      r_busy       <= 1'b0;
      r_word_valid <= 1'b0;
      r_lane_ok    <= '0;
      r_max_abs    <= '0;
      r_iter_count <= '0;
      r_done       <= 1'b0;
      r_converged  <= 1'b0;
      r_timeout    <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        r_shift[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_SHIFT;
            r_threshold  <= threshold;
            r_max_iter   <= max_iter;
            r_bit_cnt    <= '0;
            r_stable_cnt <= '0;
            r_iter_count <= '0;
            r_lane_ok    <= '0;
            r_max_abs    <= '0;
            r_done       <= 1'b0;
            r_converged  <= 1'b0;
            r_timeout    <= 1'b0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (bit_valid) begin
            for (int i = 0; i < NUM_PE; i++) begin
              r_shift[i] <= w_word[i][WIDTH-1:1];
            end
            if (w_last_bit) begin
              r_bit_cnt    <= '0;
              r_state      <= S_EVAL;
              r_word_valid <= 1'b1;
              r_lane_ok    <= w_ok;
              r_max_abs    <= w_max;
              r_iter_count <= w_iter_next;
              r_stable_cnt <= w_stable_next;
            end else begin
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
          end
        end

        S_EVAL: begin
          // Convergence is tested first so it wins over a simultaneous timeout.
          r_word_valid <= 1'b0;
          if (r_stable_cnt == SC_W'(STABLE_CNT)) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_converged <= 1'b1;
            r_busy      <= 1'b0;
          end else if ((r_max_iter != '0) && (r_iter_count == r_max_iter)) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign word_valid = r_word_valid;
  assign lane_ok    = r_lane_ok;
  assign max_abs    = r_max_abs;
  assign iter_count = r_iter_count;
  assign done       = r_done;
  assign converged  = r_converged;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_residue_convergence_monitor.sv
// -----------------------------------------------------------------------------
// tb_residue_convergence_monitor
//
// Purpose:
//   Self-checking bench for residue_convergence_monitor. Every word set sent
//   pushes its expected evaluation (lane_ok, max_abs, iter_count) onto a
//   scoreboard queue; a monitor pops and compares on each word_valid.
//   Run-level results (done/converged/timeout/busy) are checked directly.
// -----------------------------------------------------------------------------
module tb_residue_convergence_monitor;

  logic        clk_a = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        bit_valid;
  logic [3:0]  residue_in;
  logic [7:0]  threshold;
  logic [15:0] max_iter;
  logic        busy;
  logic        word_valid;
  logic [3:0]  lane_ok;
  logic [7:0]  max_abs;
  logic [15:0] iter_count;
  logic        done;
  logic        converged;
  logic        timeout;

  typedef struct {
    logic [3:0]  ok;
    logic [7:0]  mx;
    logic [15:0] it;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wv    = 0;
  int   exp_iter = 0;
  int   cur_thr  = 0;

  residue_convergence_monitor #(
    .WIDTH(8), .NUM_PE(4), .ITER_W(16), .STABLE_CNT(2)
  ) dut (
    .clk_a      (clk_a),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .residue_in (residue_in),
    .threshold  (threshold),
    .max_iter   (max_iter),
    .busy       (busy),
    .word_valid (word_valid),
    .lane_ok    (lane_ok),
    .max_abs    (max_abs),
    .iter_count (iter_count),
    .done       (done),
    .converged  (converged),
    .timeout    (timeout)
  );

  always #5 clk_a = ~clk_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference evaluation of one word set: lane i is bits [8i+7:8i].
  function automatic exp_t model(input logic [31:0] w, input int thr, input int it);
    exp_t e;
    e.ok = '0;
    e.mx = '0;
    e.it = 16'(it);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      int v;
      int a;
      b = w[8*i +: 8];
      v = int'($signed(b));
      a = (v < 0) ? -v : v;
      if (a > 127) a = 127;
      e.ok[i] = (a <= thr);
      if (a > int'(e.mx)) e.mx = 8'(a);
    end
    return e;
  endfunction

  function automatic logic [31:0] pack(input int l0, input int l1, input int l2, input int l3);
    logic [31:0] r;
    r[7:0]   = l0[7:0];
    r[15:8]  = l1[7:0];
    r[23:16] = l2[7:0];
    r[31:24] = l3[7:0];
    return r;
  endfunction

  // Scoreboard consumer: sampled on the falling edge, away from the active edge.
  always @(negedge clk_a) begin
    if (word_valid === 1'b1) begin
      exp_t e;
      n_wv++;
      if (q.size() == 0) begin
        chk("wv_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        $display("[TB] word %0d: lane_ok=%h max_abs=%0d iter=%0d (exp %h/%0d/%0d)",
                 n_wv, lane_ok, max_abs, iter_count, e.ok, e.mx, e.it);
        chk("wv_lane_ok", 32'(lane_ok), 32'(e.ok));
        chk("wv_max_abs", 32'(max_abs), 32'(e.mx));
        chk("wv_iter",    32'(iter_count), 32'(e.it));
      end
    end
  end

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic do_start(input int thr, input int mi);
    threshold = 8'(thr);
    max_iter  = 16'(mi);
    cur_thr   = thr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    exp_iter  = 0;
  endtask

  // Sends one word set LSB first. gapped inserts an idle cycle between bits;
  // start_at >= 0 pulses start (with a different threshold) at that bit.
  task automatic send_word(input logic [31:0] w, input bit gapped, input int start_at);
    exp_t e;
    exp_iter++;
    e = model(w, cur_thr, exp_iter);
    q.push_back(e);
    for (int b = 0; b < 8; b++) begin
      bit_valid = 1'b1;
      for (int i = 0; i < 4; i++) residue_in[i] = w[8*i + b];
      if (b == start_at) begin
        start     = 1'b1;
        threshold = 8'd0;
      end
      tick();
      start     = 1'b0;
      threshold = 8'(cur_thr);
      if (gapped && b != 7) begin
        bit_valid  = 1'b0;
        residue_in = 4'hF;
        tick();
      end
    end
    bit_valid  = 1'b0;
    residue_in = 4'hF;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wv0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
    residue_in = '0; threshold = '0; max_iter = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wv", 32'(word_valid), 0);
    chk("rst_lane_ok", 32'(lane_ok), 0);
    chk("rst_max_abs", 32'(max_abs), 0);
    chk("rst_iter", 32'(iter_count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_conv", 32'(converged), 0);
    chk("rst_tmo", 32'(timeout), 0);
    rst_n = 1'b1;
    tick();

    // Convergence after two passing iterations
    do_start(5, 0);
    chk("conv_busy", 32'(busy), 1);
    send_word(pack(3, -4, 0, 5), 0, -1);
    chk("conv_notdone", 32'(done), 0);
    send_word(pack(3, -4, 0, 5), 0, -1);
    chk("conv_done", 32'(done), 1);
    chk("conv_conv", 32'(converged), 1);
    chk("conv_tmo", 32'(timeout), 0);
    chk("conv_iter", 32'(iter_count), 2);
    chk("conv_busy_lo", 32'(busy), 0);

    // Sign and saturation, threshold 127 (restart from DONE)
    do_start(127, 0);
    send_word(pack(-128, 127, -1, 0), 0, -1);
    chk("sat_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort1_busy", 32'(busy), 0);
    chk("abort1_iter", 32'(iter_count), 0);
    // threshold 126: lanes 0,1 fail and the stable count restarts
    do_start(126, 0);
    send_word(pack(-128, 127, -1, 0), 0, -1);
    send_word(pack(0, 0, 0, 0), 0, -1);
    chk("stab_notdone", 32'(done), 0);
    send_word(pack(0, 0, 0, 0), 0, -1);
    chk("stab_done", 32'(done), 1);
    chk("stab_conv", 32'(converged), 1);
    chk("stab_iter", 32'(iter_count), 3);

    // Timeout at max_iter=3
    do_start(10, 3);
    for (int k = 0; k < 3; k++) send_word(pack(20, 0, 0, 0), 0, -1);
    chk("tmo_done", 32'(done), 1);
    chk("tmo_tmo", 32'(timeout), 1);
    chk("tmo_conv", 32'(converged), 0);
    chk("tmo_iter", 32'(iter_count), 3);

    // max_iter=0 never times out
    do_start(10, 0);
    for (int k = 0; k < 50; k++) send_word(pack(20, 0, 0, 0), 0, -1);
    chk("unl_busy", 32'(busy), 1);
    chk("unl_done", 32'(done), 0);
    chk("unl_iter", 32'(iter_count), 50);

    // Gapped bits give exactly one word
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_start(100, 0);
    wv0 = n_wv;
    send_word(pack(8'h5A, 0, 0, 0), 1, -1);
    chk("gap_wv_count", 32'(n_wv - wv0), 1);

    // Abort after 4 bits, then a fresh word must count from bit 0
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_start(5, 0);
    bit_valid  = 1'b1;
    residue_in = 4'hF;
    repeat (4) tick();
    bit_valid = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    chk("abort2_busy", 32'(busy), 0);
    do_start(5, 0);
    send_word(pack(1, 2, 3, 4), 0, -1);
    // start during SHIFT is ignored
    send_word(pack(-2, 0, 1, 5), 0, 3);
    chk("ign_done", 32'(done), 1);
    chk("ign_conv", 32'(converged), 1);
    chk("ign_iter", 32'(iter_count), 2);

    // abort beats start in DONE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", 32'(busy), 0);
    chk("abort_wins_done", 32'(done), 0);

    // Asynchronous reset while in DONE
    do_start(5, 0);
    send_word(pack(0, 0, 0, 0), 0, -1);
    send_word(pack(0, 0, 0, 0), 0, -1);
    chk("ar_pre_done", 32'(done), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_done", 32'(done), 0);
    chk("ar_conv", 32'(converged), 0);
    chk("ar_iter", 32'(iter_count), 0);
    chk("ar_max_abs", 32'(max_abs), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(5, 0);
    send_word(pack(3, -4, 0, 5), 0, -1);
    send_word(pack(3, -4, 0, 5), 0, -1);
    chk("ar_run_done", 32'(done), 1);
    chk("ar_run_conv", 32'(converged), 1);
    chk("ar_run_iter", 32'(iter_count), 2);

    tick();
    chk("sb_drain", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
